interface_hcsr04: RTL and testbench

Upstream measurement stage of the digital tape measure. On a `medir` pulse from the tape-measure control unit it fires the HC-SR04 trigger, times the returned echo and converts the width to whole centimetres as three BCD digits. It then raises `pronto`, which the control unit consumes as `medida_pronto` before transmitting hundreds, tens and units.

---
 rtl/trena_pkg.sv | 33 +++
 rtl/interface_hcsr04_if.sv | 35 +++
 rtl/interface_hcsr04_contador_cm_bcd.sv | 66 ++++++
 rtl/interface_hcsr04.sv | 162 ++++++++++++++++
 tb/tb_interface_hcsr04.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trena_pkg.sv
// Shared definitions for the tape-measure datapath: FSM state codes, the
// debug code shown for an illegal state, and default timing parameters.
package trena_pkg;

    // State encoding doubles as the db_estado debug code.
    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_PREPARACAO    = 4'd1,
        ST_ENVIA_TRIGGER = 4'd2,
        ST_ESPERA_ECHO   = 4'd3,
        ST_MEDE_ECHO     = 4'd4,
        ST_ARMAZENA      = 4'd5,
        ST_FINAL_MEDIDA  = 4'd6
    } estado_t;

    localparam logic [3:0]  DB_ESTADO_ERRO  = 4'hE;
    localparam logic [11:0] MEDIDA_SATURADA = 12'h999;

    // Defaults for a 50 MHz clock.
    localparam int TRIGGER_CYCLES_DEF = 500;
    localparam int CYCLES_PER_CM_DEF  = 2941;
    localparam int TIMEOUT_CYCLES_DEF = 1_250_000;

    // Debug code for a state: its own encoding when legal, E otherwise.
    function automatic logic [3:0] codigo_debug(input estado_t e);
        case (e)
            ST_INICIAL, ST_PREPARACAO, ST_ENVIA_TRIGGER, ST_ESPERA_ECHO,
            ST_MEDE_ECHO, ST_ARMAZENA, ST_FINAL_MEDIDA: codigo_debug = e;
            default:                                    codigo_debug = DB_ESTADO_ERRO;
        endcase
    endfunction

endpackage

// File: rtl/interface_hcsr04_if.sv
// Signal bundle between the HC-SR04 measurement stage, the sensor and the
// tape-measure control unit. The slave modport is the measurement stage.
interface interface_hcsr04_if;

    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    // Control unit + sensor side.
    modport master (
        output medir,
        output echo,
        input  trigger,
        input  medida,
        input  pronto,
        input  erro,
        input  db_estado
    );

    // Measurement stage side.
    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output medida,
        output pronto,
        output erro,
        output db_estado
    );

endinterface

// File: rtl/interface_hcsr04_contador_cm_bcd.sv
// Echo-width to centimetre converter: a modulo-CYCLES_PER_CM divider whose
// wrap increments a 3-digit BCD counter that saturates at 999.
module contador_cm_bcd
    import trena_pkg::*;
#(
    parameter int CYCLES_PER_CM = CYCLES_PER_CM_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        conta,
    output logic [11:0] bcd
);

    localparam int DIV_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    logic [DIV_W-1:0] r_divisor;
    logic [3:0]       r_centena;
    logic [3:0]       r_dezena;
    logic [3:0]       r_unidade;

    logic w_fim_cm;
    logic w_saturado;

    assign w_fim_cm   = conta && (r_divisor == DIV_W'(CYCLES_PER_CM - 1));
    assign w_saturado = (r_centena == 4'd9) && (r_dezena == 4'd9) && (r_unidade == 4'd9);

    // Divider: counts echo clocks, wraps to 0 after each whole centimetre.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_divisor <= '0;
        end else if (zera) begin
            r_divisor <= '0;
        end else if (conta) begin
            r_divisor <= w_fim_cm ? '0 : r_divisor + 1'b1;
        end
    end

    // BCD counter: ripple carry between digits, holds at 999 instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_centena <= 4'd0;
            r_dezena  <= 4'd0;
            r_unidade <= 4'd0;
        end else if (zera) begin
            r_centena <= 4'd0;
            r_dezena  <= 4'd0;
            r_unidade <= 4'd0;
        end else if (w_fim_cm && !w_saturado) begin
            if (r_unidade == 4'd9) begin
                r_unidade <= 4'd0;
                if (r_dezena == 4'd9) begin
                    r_dezena  <= 4'd0;
                    r_centena <= r_centena + 4'd1;
                end else begin
                    r_dezena <= r_dezena + 4'd1;
                end
            end else begin
                r_unidade <= r_unidade + 4'd1;
            end
        end
    end

    assign bcd = {r_centena, r_dezena, r_unidade};

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 measurement stage: fires the trigger on medir, times the echo and
// presents the distance in whole centimetres as three BCD digits.
// Optional echo watchdog enabled by defining HCSR04_TIMEOUT_EN.
module interface_hcsr04
    import trena_pkg::*;
#(
    parameter int TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
    parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic                  clock,
    input logic                  reset,
    interface_hcsr04_if.slave    bus
);

    localparam int TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;

    estado_t          r_estado;
    logic [TRIG_W-1:0] r_cnt_trigger;
    logic             r_trigger;
    logic             r_pronto;
    logic             r_erro;
    logic             r_timeout;
    logic [11:0]      r_medida;
    logic             r_echo_meta;
    logic             r_echo_s;

    logic        w_zera;
    logic        w_conta;
    logic        w_timeout;
    logic        w_fim_trigger;
    logic [11:0] w_bcd;

    // Two-flop synchronizer for the asynchronous echo input.
    // NOTE: non-blocking assignments keep these as two distinct flops; a
    // blocking pair would collapse into one and defeat the synchronizer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= bus.echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    // Count the first echo clock already in espera_echo so the measured
    // width matches the synchronized pulse width exactly.
    assign w_zera  = (r_estado == ST_PREPARACAO);
    assign w_conta = r_echo_s && ((r_estado == ST_ESPERA_ECHO) || (r_estado == ST_MEDE_ECHO));
    assign w_fim_trigger = (r_cnt_trigger == TRIG_W'(TRIGGER_CYCLES - 1));

`ifdef HCSR04_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_watchdog;

    // Watchdog: cleared while the trigger is sent, runs while waiting for or
    // measuring the echo, so both a missing and a stuck-high echo time out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_watchdog <= '0;
        end else if (r_estado == ST_ENVIA_TRIGGER) begin
            r_watchdog <= '0;
        end else if ((r_estado == ST_ESPERA_ECHO) || (r_estado == ST_MEDE_ECHO)) begin
            r_watchdog <= r_watchdog + 1'b1;
        end
    end

    assign w_timeout = ((r_estado == ST_ESPERA_ECHO) || (r_estado == ST_MEDE_ECHO)) &&
                       (r_watchdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    contador_cm_bcd #(
        .CYCLES_PER_CM (CYCLES_PER_CM)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera),
        .conta (w_conta),
        .bcd   (w_bcd)
    );

    // Measurement FSM with registered trigger, pronto, erro and medida.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado      <= ST_INICIAL;
            r_cnt_trigger <= '0;
            r_trigger     <= 1'b0;
            r_pronto      <= 1'b0;
            r_erro        <= 1'b0;
            r_timeout     <= 1'b0;
            r_medida      <= 12'h000;
        end else begin
            case (r_estado)
                ST_INICIAL: begin
                    r_trigger <= 1'b0;
                    r_pronto  <= 1'b0;
                    if (bus.medir) begin
                        r_estado <= ST_PREPARACAO;
                    end
                end
                ST_PREPARACAO: begin
                    r_cnt_trigger <= '0;
                    r_timeout     <= 1'b0;
                    r_trigger     <= 1'b1;
                    r_estado      <= ST_ENVIA_TRIGGER;
                end
                ST_ENVIA_TRIGGER: begin
                    if (w_fim_trigger) begin
                        r_trigger <= 1'b0;
                        r_estado  <= ST_ESPERA_ECHO;
                    end else begin
                        r_cnt_trigger <= r_cnt_trigger + 1'b1;
                    end
                end
                ST_ESPERA_ECHO: begin
                    if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_estado  <= ST_ARMAZENA;
                    end else if (r_echo_s) begin
                        r_estado <= ST_MEDE_ECHO;
                    end
                end
                ST_MEDE_ECHO: begin
                    if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_estado  <= ST_ARMAZENA;
                    end else if (!r_echo_s) begin
                        r_estado <= ST_ARMAZENA;
                    end
                end
                ST_ARMAZENA: begin
                    r_medida <= r_timeout ? MEDIDA_SATURADA : w_bcd;
                    r_erro   <= r_timeout;
                    r_pronto <= 1'b1;
                    r_estado <= ST_FINAL_MEDIDA;
                end
                ST_FINAL_MEDIDA: begin
                    r_pronto <= 1'b0;
                    r_estado <= ST_INICIAL;
                end
                default: begin
                    r_trigger <= 1'b0;
                    r_pronto  <= 1'b0;
                    r_estado  <= ST_INICIAL;
                end
            endcase
        end
    end

    assign bus.trigger   = r_trigger;
    assign bus.pronto    = r_pronto;
    assign bus.erro      = r_erro;
    assign bus.medida    = r_medida;
    assign bus.db_estado = codigo_debug(r_estado);

endmodule

// File: tb/tb_interface_hcsr04.sv
// Self-checking bench for interface_hcsr04 with scaled-down timing parameters.
// Expected distances come from floor(width / CYCLES_PER_CM) capped at 999.
module tb_interface_hcsr04;

    localparam int T_TRIG = 20;
    localparam int C_CM   = 7;
    localparam int T_OUT  = 20000;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    interface_hcsr04_if bus ();

    interface_hcsr04 #(
        .TRIGGER_CYCLES (T_TRIG),
        .CYCLES_PER_CM  (C_CM),
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: whole centimetres, saturated at 999, as three BCD digits.
    function automatic logic [11:0] model_bcd(input int width);
        int cm;
        cm = width / C_CM;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    // Pulse medir for one cycle, measure delay to trigger and its width.
    task automatic fire(output int delay, output int width);
        int n;
        delay = 0;
        width = 0;
        n = 0;
        @(negedge clock);
        bus.medir = 1'b1;
        @(negedge clock);
        bus.medir = 1'b0;
        delay = 1;
        while (bus.trigger !== 1'b1 && n < 50) begin
            @(negedge clock);
            delay++;
            n++;
        end
        while (bus.trigger === 1'b1 && width < 10000) begin
            @(negedge clock);
            width++;
        end
    endtask

    task automatic echo_pulse(input int width);
        bus.echo = 1'b1;
        repeat (width) @(negedge clock);
        bus.echo = 1'b0;
    endtask

    // Wait (bounded) for pronto; capture medida/erro and pronto width.
    task automatic wait_pronto(input int budget, output int lat, output int cnt,
                               output logic [11:0] med, output logic er);
        lat = 0;
        cnt = 0;
        med = 'x;
        er  = 'x;
        while (bus.pronto !== 1'b1 && lat < budget) begin
            @(negedge clock);
            lat++;
        end
        med = bus.medida;
        er  = bus.erro;
        while (bus.pronto === 1'b1 && cnt < 10) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    // One complete measurement with an echo of the given width.
    task automatic run_meas(input int width, input string name);
        int          dly, tw, lat, cnt;
        logic [11:0] med;
        logic        er;
        fire(dly, tw);
        echo_pulse(width);
        wait_pronto(width + 50, lat, cnt, med, er);
        vectors++;
        if (med !== model_bcd(width)) begin
            miscompares++;
            $display("FAIL %s medida: got %h expected %h (width %0d)", name, med, model_bcd(width), width);
        end
        vectors++;
        if (er !== 1'b0) begin
            miscompares++;
            $display("FAIL %s erro: got %b expected 0", name, er);
        end
        vectors++;
        if (cnt !== 1) begin
            miscompares++;
            $display("FAIL %s pronto_width: got %0d expected 1", name, cnt);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL %s pronto_latency: got %0d expected 4 negedges after echo fall", name, lat);
        end
        vectors++;
        if (bus.db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL %s db_estado_after: got %0d expected 0", name, bus.db_estado);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        vectors++;
        if ({bus.trigger, bus.pronto, bus.erro, bus.medida, bus.db_estado} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got trig=%b pronto=%b erro=%b medida=%h db=%h expected all 0",
                     bus.trigger, bus.pronto, bus.erro, bus.medida, bus.db_estado);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if (bus.db_estado !== 4'd0 || bus.trigger !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got db=%h trig=%b expected 0/0", bus.db_estado, bus.trigger);
        end
    endtask

    task automatic test_trigger();
        int          dly, tw, lat, cnt;
        logic [11:0] med;
        logic        er;
        fire(dly, tw);
        vectors++;
        if (dly !== 2) begin
            miscompares++;
            $display("FAIL trigger_delay: got %0d expected 2", dly);
        end
        vectors++;
        if (tw !== T_TRIG) begin
            miscompares++;
            $display("FAIL trigger_width: got %0d expected %0d", tw, T_TRIG);
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (bus.db_estado !== 4'd3) begin
            miscompares++;
            $display("FAIL espera_echo_state: got %0d expected 3", bus.db_estado);
        end
        echo_pulse(5 * C_CM);
        wait_pronto(100, lat, cnt, med, er);
        vectors++;
        if (med !== 12'h005) begin
            miscompares++;
            $display("FAIL trigger_followup_medida: got %h expected 005", med);
        end
    endtask

    task automatic test_conversion();
        run_meas(123 * C_CM, "width_123cm");
        run_meas(C_CM - 1, "width_below_1cm");
        run_meas(C_CM, "width_exact_1cm");
        run_meas(1005 * C_CM, "width_saturated");
    endtask

    task automatic test_random();
        int cm, r;
        for (int i = 0; i < 8; i++) begin
            cm = $urandom_range(0, 250);
            r  = $urandom_range(1, C_CM - 2);
            run_meas(cm * C_CM + r, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_reset_mid_echo();
        int dly, tw;
        fire(dly, tw);
        bus.echo = 1'b1;
        repeat (50) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.trigger, bus.pronto, bus.erro, bus.medida, bus.db_estado} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid_echo: got trig=%b pronto=%b erro=%b medida=%h db=%h expected all 0",
                     bus.trigger, bus.pronto, bus.erro, bus.medida, bus.db_estado);
        end
        bus.echo = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        run_meas(42 * C_CM, "after_reset_42cm");
    endtask

    task automatic test_medir_ignored();
        int          dly, tw, lat, cnt, extra;
        int          width;
        logic [11:0] med;
        logic        er;
        width = 300 * C_CM + 3;
        fire(dly, tw);
        bus.echo = 1'b1;
        repeat (100) @(negedge clock);
        vectors++;
        if (bus.db_estado !== 4'd4) begin
            miscompares++;
            $display("FAIL mede_echo_state: got %0d expected 4", bus.db_estado);
        end
        bus.medir = 1'b1;
        @(negedge clock);
        bus.medir = 1'b0;
        repeat (width - 101) @(negedge clock);
        bus.echo = 1'b0;
        wait_pronto(width + 50, lat, cnt, med, er);
        vectors++;
        if (med !== model_bcd(width)) begin
            miscompares++;
            $display("FAIL medir_ignored_medida: got %h expected %h", med, model_bcd(width));
        end
        extra = 0;
        repeat (3 * T_TRIG) begin
            if (bus.pronto === 1'b1 || bus.trigger === 1'b1) extra++;
            @(negedge clock);
        end
        vectors++;
        if (extra !== 0 || cnt !== 1) begin
            miscompares++;
            $display("FAIL medir_ignored_single: got %0d extra active cycles, pronto width %0d expected 0 and 1",
                     extra, cnt);
        end
        vectors++;
        if (bus.db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL medir_ignored_idle: got %0d expected 0", bus.db_estado);
        end
    endtask

`ifdef HCSR04_TIMEOUT_EN
    task automatic test_timeout();
        int          dly, tw, lat, cnt;
        logic [11:0] med;
        logic        er;
        fire(dly, tw);
        wait_pronto(T_OUT + 100, lat, cnt, med, er);
        vectors++;
        if (med !== 12'h999 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_result: got medida=%h erro=%b expected 999/1", med, er);
        end
        vectors++;
        if (lat < T_OUT || lat > T_OUT + 3 || cnt !== 1) begin
            miscompares++;
            $display("FAIL timeout_timing: got latency %0d pronto width %0d expected ~%0d and 1",
                     lat, cnt, T_OUT);
        end
        run_meas(17 * C_CM + 2, "after_timeout");
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.medir   = 1'b0;
        bus.echo    = 1'b0;
        test_reset();
        test_trigger();
        test_conversion();
        test_random();
        test_reset_mid_echo();
        test_medir_ignored();
`ifdef HCSR04_TIMEOUT_EN
        test_timeout();
`endif
        run_meas(999 * C_CM, "back_to_back_999");
        run_meas(1 * C_CM + 1, "back_to_back_1");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
